// File: rtl/alu_rf_32_core_if.sv
// ============================================================================
// Module      : alu_rf_32_core_if
// Description : Decoder-to-datapath bus for the register-file/ALU execute core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_rf_32_core_if;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  control;
    logic        write_enabled;
    logic        load_enabled;
    logic [31:0] load_data;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        overflow;

    // Decoder side drives indices and controls, observes datapath outputs.
    modport master (
        output rs, rt, rd, control, write_enabled, load_enabled, load_data,
        input  out_a, out_b, result, cout, zero, overflow
    );

    modport slave (
        input  rs, rt, rd, control, write_enabled, load_enabled, load_data,
        output out_a, out_b, result, cout, zero, overflow
    );
endinterface

`default_nettype wire

// File: rtl/alu_rf_32_core.sv
// ============================================================================
// Module      : alu_rf_32_core
// Description : 32x32 register file (2 async reads, 1 sync write) feeding a
//               single-cycle 32-bit MIPS-style ALU with write-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rf_32_core (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_rf_32_core_if.slave   bus
);

    localparam logic [3:0] c_OP_AND = 4'h0;
    localparam logic [3:0] c_OP_OR  = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h6;
    localparam logic [3:0] c_OP_SLT = 4'h7;
    localparam logic [3:0] c_OP_NOR = 4'hC;

    logic [31:0] r_regs [0:31];

    logic [31:0] w_s;
    logic [31:0] w_t;
    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic [31:0] w_result;
    logic        w_cout;
    logic        w_ovf;

    // r0 is forced to zero on read so its storage never matters.
    assign w_s = (bus.rs == 5'd0) ? 32'd0 : r_regs[bus.rs];
    assign w_t = (bus.rt == 5'd0) ? 32'd0 : r_regs[bus.rt];

    assign w_add     = {1'b0, w_s} + {1'b0, w_t};
    assign w_sub     = {1'b0, w_s} + {1'b0, ~w_t} + 33'd1;
    assign w_add_ovf = (w_s[31] == w_t[31]) && (w_add[31] != w_s[31]);
    assign w_sub_ovf = (w_s[31] != w_t[31]) && (w_sub[31] != w_s[31]);

    always_comb begin
        w_result = 32'd0;
        w_cout   = 1'b0;
        w_ovf    = 1'b0;
        case (bus.control)
            c_OP_AND: w_result = w_s & w_t;
            c_OP_OR:  w_result = w_s | w_t;
            c_OP_ADD: begin
                w_result = w_add[31:0];
                w_cout   = w_add[32];
                w_ovf    = w_add_ovf;
            end
            c_OP_SUB: begin
                w_result = w_sub[31:0];
                w_cout   = w_sub[32];
                w_ovf    = w_sub_ovf;
            end
            // Signed less-than: sign of the difference corrected by overflow.
            c_OP_SLT: w_result = {31'd0, w_sub[31] ^ w_sub_ovf};
            c_OP_NOR: w_result = ~(w_s | w_t);
            default:  w_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (bus.write_enabled && (bus.rd != 5'd0)) begin
            r_regs[bus.rd] <= bus.load_enabled ? bus.load_data : w_result;
        end
    end

    assign bus.out_a    = w_s;
    assign bus.out_b    = w_t;
    assign bus.result   = w_result;
    assign bus.cout     = w_cout;
    assign bus.zero     = (w_result == 32'd0);
    assign bus.overflow = w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_alu_rf_32_core.sv
// ============================================================================
// Module      : tb_alu_rf_32_core
// Description : Directed self-checking bench for alu_rf_32_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rf_32_core;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_rf_32_core_if bus ();

    alu_rf_32_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] idx, input logic [31:0] val);
        bus.rd            = idx;
        bus.load_data     = val;
        bus.load_enabled  = 1'b1;
        bus.write_enabled = 1'b1;
        tick();
        bus.write_enabled = 1'b0;
        bus.load_enabled  = 1'b0;
    endtask

    task automatic op(input logic [3:0] ctrl, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        bus.control       = ctrl;
        bus.rd            = d;
        bus.rs            = s;
        bus.rt            = t;
        bus.load_enabled  = 1'b0;
        bus.write_enabled = 1'b1;
        tick();
        bus.write_enabled = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
        bus.rs = idx;
        #1;
        val = bus.out_a;
    endtask

    task automatic alu(input logic [3:0] ctrl, input logic [4:0] s, input logic [4:0] t);
        bus.control = ctrl;
        bus.rs      = s;
        bus.rt      = t;
        #1;
    endtask

    initial begin
        logic [31:0] v;
        int          iters;
        tests = 0;
        fails = 0;
        reset             = 1'b1;
        bus.rs            = 5'd0;
        bus.rt            = 5'd0;
        bus.rd            = 5'd0;
        bus.control       = 4'h2;
        bus.write_enabled = 1'b0;
        bus.load_enabled  = 1'b0;
        bus.load_data     = 32'd0;
        tick();
        reset = 1'b0;

        // Arbitrary writes, then a reset pulse must clear everything.
        load(5'd7, 32'h1234_5678);
        load(5'd31, 32'hABCD_EF01);
        load(5'd16, 32'h0000_0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rs = i[4:0];
            bus.rt = 5'(31 - i);
            #1;
            check($sformatf("rst_out_a[%0d]", i), bus.out_a, 32'd0);
            check($sformatf("rst_out_b[%0d]", 31 - i), bus.out_b, 32'd0);
        end
        alu(4'h2, 5'd3, 5'd4);
        check("rst_add_result", bus.result, 32'd0);
        check("rst_add_zero", {31'd0, bus.zero}, 32'd1);

        // Loads and r0 immutability.
        load(5'd1, 32'd1);
        load(5'd2, 32'd16);
        load(5'd3, 32'd4);
        read_reg(5'd1, v); check("load_r1", v, 32'd1);
        read_reg(5'd2, v); check("load_r2", v, 32'd16);
        read_reg(5'd3, v); check("load_r3", v, 32'd4);
        load(5'd0, 32'hDEAD_BEEF);
        read_reg(5'd0, v); check("r0_stays_zero", v, 32'd0);

        // Read-during-write returns old value; new value visible after the edge.
        bus.rs            = 5'd12;
        bus.rd            = 5'd12;
        bus.load_data     = 32'h0000_0055;
        bus.load_enabled  = 1'b1;
        bus.write_enabled = 1'b1;
        #1;
        check("rdw_before_edge", bus.out_a, 32'd0);
        tick();
        bus.write_enabled = 1'b0;
        bus.load_enabled  = 1'b0;
        check("rdw_after_edge", bus.out_a, 32'h0000_0055);

        // Loop program: r4 += r2; r3 -= r1; r5 = slt(r3, r0) until r5 == 1.
        load(5'd4, 32'd0);
        iters = 0;
        v     = 32'd0;
        while (v != 32'd1 && iters < 10) begin
            op(4'h2, 5'd4, 5'd4, 5'd2);
            op(4'h6, 5'd3, 5'd3, 5'd1);
            op(4'h7, 5'd5, 5'd3, 5'd0);
            iters++;
            read_reg(5'd5, v);
        end
        check("loop_iterations", iters, 32'd5);
        read_reg(5'd3, v); check("loop_r3", v, 32'hFFFF_FFFF);
        read_reg(5'd4, v); check("loop_r4", v, 32'd80);
        read_reg(5'd5, v); check("loop_r5", v, 32'd1);

        // Add flags.
        load(5'd6, 32'h7FFF_FFFF);
        load(5'd7, 32'hFFFF_FFFF);
        alu(4'h2, 5'd6, 5'd1);
        check("add_ovf_result", bus.result, 32'h8000_0000);
        check("add_ovf_overflow", {31'd0, bus.overflow}, 32'd1);
        check("add_ovf_cout", {31'd0, bus.cout}, 32'd0);
        alu(4'h2, 5'd7, 5'd1);
        check("add_wrap_result", bus.result, 32'd0);
        check("add_wrap_cout", {31'd0, bus.cout}, 32'd1);
        check("add_wrap_zero", {31'd0, bus.zero}, 32'd1);
        check("add_wrap_overflow", {31'd0, bus.overflow}, 32'd0);

        // Sub / slt.
        load(5'd8, 32'd5);
        load(5'd9, 32'h8000_0000);
        alu(4'h6, 5'd8, 5'd8);
        check("sub_eq_result", bus.result, 32'd0);
        check("sub_eq_cout", {31'd0, bus.cout}, 32'd1);
        check("sub_eq_zero", {31'd0, bus.zero}, 32'd1);
        alu(4'h6, 5'd0, 5'd1);
        check("sub_neg_result", bus.result, 32'hFFFF_FFFF);
        check("sub_neg_cout", {31'd0, bus.cout}, 32'd0);
        check("sub_neg_overflow", {31'd0, bus.overflow}, 32'd0);
        alu(4'h6, 5'd9, 5'd1);
        check("sub_ovf_result", bus.result, 32'h7FFF_FFFF);
        check("sub_ovf_overflow", {31'd0, bus.overflow}, 32'd1);
        alu(4'h7, 5'd9, 5'd1);
        check("slt_min_lt_1", bus.result, 32'd1);
        check("slt_flags", {30'd0, bus.cout, bus.overflow}, 32'd0);
        alu(4'h7, 5'd1, 5'd7);
        check("slt_1_lt_m1", bus.result, 32'd0);

        // Logic ops and undefined code.
        load(5'd10, 32'hF0F0_F0F0);
        load(5'd11, 32'h0FF0_0FF0);
        alu(4'h0, 5'd10, 5'd11);
        check("and_result", bus.result, 32'h00F0_00F0);
        check("and_flags", {30'd0, bus.cout, bus.overflow}, 32'd0);
        alu(4'h1, 5'd10, 5'd11);
        check("or_result", bus.result, 32'hFFF0_FFF0);
        alu(4'hC, 5'd10, 5'd11);
        check("nor_result", bus.result, 32'h000F_000F);
        alu(4'h5, 5'd10, 5'd11);
        check("undef_result", bus.result, 32'd0);
        check("undef_zero", {31'd0, bus.zero}, 32'd1);

        // write_enabled low across edges: nothing changes.
        bus.rd           = 5'd10;
        bus.load_enabled = 1'b1;
        bus.load_data    = 32'd0;
        bus.control      = 4'h2;
        repeat (3) tick();
        bus.load_enabled = 1'b0;
        bus.rd           = 5'd11;
        repeat (2) tick();
        read_reg(5'd10, v); check("hold_r10", v, 32'hF0F0_F0F0);
        read_reg(5'd11, v); check("hold_r11", v, 32'h0FF0_0FF0);
        read_reg(5'd4, v);  check("hold_r4", v, 32'd80);

        // Reset wins over a simultaneous write.
        bus.rd            = 5'd13;
        bus.load_data     = 32'h1111_2222;
        bus.load_enabled  = 1'b1;
        bus.write_enabled = 1'b1;
        reset             = 1'b1;
        tick();
        reset             = 1'b0;
        bus.write_enabled = 1'b0;
        bus.load_enabled  = 1'b0;
        read_reg(5'd13, v); check("reset_priority_r13", v, 32'd0);
        read_reg(5'd10, v); check("reset_clears_r10", v, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_rf_32_core.md
Name: alu_rf_32_core

Overview:
- Single-cycle MIPS-style execute datapath: a 32x32-bit register file (two asynchronous read ports, one synchronous write port) feeding a 32-bit ALU.
- The ALU result is written back to the destination register on the clock edge.
- A load path lets test/boot logic write arbitrary constants into registers.
- Sits under the instruction decoder, which drives rs/rt/rd/control/write_enabled per instruction.

Parameters:
- None. Data width is fixed at 32 bits; register count is fixed at 32.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- rs  input  5  register index for ALU operand s (port A)
- rt  input  5  register index for ALU operand t (port B)
- rd  input  5  destination register index
- control  input  4  ALU operation select
- write_enabled  input  1  write back to rd at rising edge
- load_enabled  input  1  when high, write data is load_data instead of the ALU result
- load_data  input  32  constant for load writes
- out_a  output  32  register[rs], the ALU s operand
- out_b  output  32  register[rt], the ALU t operand
- result  output  32  ALU result (combinational)
- cout  output  1  ALU carry out
- zero  output  1  result == 0
- overflow  output  1  signed overflow

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (port reset). Reset has priority over any write.
- Register file:
  - 32 entries x 32 bits.
  - Register 0 always reads 0; writes to index 0 are ignored.
  - Reads are combinational: out_a = reg[rs], out_b = reg[rt].
- Write: at the rising edge of clk, if reset=0, write_enabled=1 and rd!=0, then reg[rd] <= (load_enabled ? load_data : result).
- Read-during-write: a read of rd in the same cycle returns the old value; there is no bypass. The new value is visible immediately after the edge.
- Write-back latency is one cycle. The ALU and all flags are purely combinational.
- Reset: at a rising edge with reset=1, all registers become 0. Outputs are then combinational functions of zeroed registers: out_a=out_b=0; result and flags follow control (e.g. add gives result=0, zero=1).
- ALU operations (s=out_a, t=out_b):
  - 0x0 and: result = s & t
  - 0x1 or: result = s | t
  - 0x2 add: result = s + t (mod 2^32); cout = carry out of bit 31; overflow = signed overflow (operands same sign, result sign differs)
  - 0x6 sub: result = s + ~t + 1; cout = carry out of bit 31 (1 when s >= t unsigned, no borrow); overflow = signed overflow (operands differ in sign, result sign differs from s)
  - 0x7 slt: result = 1 if s < t signed (sign of s-t XOR overflow of s-t), else 0; cout=0; overflow=0
  - 0xC nor: result = ~(s | t)
  - Any other code: result = 0
- cout and overflow are 0 for every operation other than add and sub.
- zero = (result == 0) for every code, including undefined codes (result 0 gives zero=1).
- X-free: with write_enabled=0, register contents never change.

Test Plan:
- Reset: pulse reset one cycle after arbitrary writes -> out_a=out_b=0 for every rs/rt index 0..31.
- Load and r0: load r1=1, r2=16, r3=4 -> out_a reads 1/16/4. Load r0=0xDEADBEEF -> r0 still reads 0.
- Loop program: with r4=0, repeat {add r4,r4,r2; sub r3,r3,r1; slt r5,r3,r0} until r5=1 -> r3=0xFFFFFFFF, r4=80 (5 iterations), r5=1.
- Add flags:
  - 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, cout=0
  - 0xFFFFFFFF+1 -> result 0, cout=1, zero=1, overflow=0
- Sub/slt:
  - 5-5 -> 0, cout=1, zero=1
  - 0-1 -> 0xFFFFFFFF, cout=0, overflow=0
  - 0x80000000-1 -> overflow=1
  - slt(0x80000000, 1) -> 1
  - slt(1, 0xFFFFFFFF) -> 0
- Logic ops and undefined code, with s=0xF0F0F0F0, t=0x0FF00FF0:
  - and -> 0x00F000F0
  - or -> 0xFFF0FFF0
  - nor -> 0x000F000F
  - code 0x5 -> result 0, zero=1
  - write_enabled=0 across edges -> no register changes
